// File: rtl/pipe_mem_pkg.sv
// -----------------------------------------------------------------------------
// pipe_mem_pkg
// Shared definitions for the unified-memory arbiter:
//   state_e      - sequencer states (IDLE -> ISSUE -> WAIT -> DONE)
//   SRC_IF/SRC_D - encoding of the granted requester
//   DEF_AW       - default word-address width
//   DEF_MEM_LAT  - default memory read latency (cycles, 1..15)
//   CNT_W        - latency counter width (covers MEM_LAT-1 up to 14)
// -----------------------------------------------------------------------------
package pipe_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_D  = 1'b1;

    localparam int DEF_AW      = 10;
    localparam int DEF_MEM_LAT = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/pipe_mem_lat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_mem_lat_cnt
// Loadable down-counter that times the memory latency window.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - asynchronous reset, active-high (counter clears to 0)
//   load_i     - load load_val_i (has priority over decrement)
//   load_val_i - value to load
//   dec_i      - decrement by one; saturates at zero
//   zero_o     - counter currently equals zero
// -----------------------------------------------------------------------------
module pipe_mem_lat_cnt
    import pipe_mem_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_mem_arbiter
// Shares one single-port unified memory between the fetch stage and the
// memory stage. Each access runs IDLE -> ISSUE -> WAIT -> DONE; a request
// seen in IDLE at cycle T completes (ready pulse) at T+MEM_LAT+2.
//
// Build option: define PIPE_MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise data always beats fetch.
//
// Ports:
//   clk_i, rst_i             - clock / asynchronous active-high reset
//   if_req_i, if_addr_i      - fetch request (held until if_ready_o)
//   if_rdata_o, if_ready_o   - fetched word, one-cycle completion pulse
//   d_req_i, d_we_i          - data request (held until d_ready_o), 1=write
//   d_addr_i, d_wdata_i      - data word address / write data
//   d_rdata_o, d_ready_o     - read data, one-cycle completion pulse
//   mem_en_o, mem_we_o       - memory strobe (one cycle per access) / write
//   mem_addr_o, mem_wdata_o  - memory word address / write data
//   mem_rdata_i              - memory read data, valid MEM_LAT after mem_en
//   pipe_stall_o             - some requester is still waiting
// -----------------------------------------------------------------------------
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [31:0]   if_rdata_o,
    output logic          if_ready_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [31:0]   d_wdata_i,
    output logic [31:0]   d_rdata_o,
    output logic          d_ready_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          pipe_stall_o
);

    // WAIT lasts MEM_LAT cycles: counter starts at MEM_LAT-1 and the capture
    // happens in the cycle where it reads zero.
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_e        state_q;
    logic          src_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          if_ready_q;
    logic          d_ready_q;
    logic          grant_d;
    logic          cnt_zero;

`ifdef PIPE_MEM_ARB_RR_EN
    logic last_grant_q;

    // On a tie the side that did not win last time goes first.
    always_comb begin
        grant_d = d_req_i;
        if (d_req_i && if_req_i) begin
            grant_d = (last_grant_q == SRC_IF);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= SRC_IF;
        end else if ((state_q == ST_IDLE) && (if_req_i || d_req_i)) begin
            last_grant_q <= grant_d ? SRC_D : SRC_IF;
        end
    end
`else
    // Data stage always wins a tie.
    assign grant_d = d_req_i;
`endif

    pipe_mem_lat_cnt u_lat_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (LAT_M1),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (if_req_i || d_req_i) begin
                        // Strobe is raised here so it is high for exactly
                        // the ISSUE cycle.
                        src_q       <= grant_d ? SRC_D : SRC_IF;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_d & d_we_i;
                        mem_addr_q  <= grant_d ? d_addr_i : if_addr_i;
                        mem_wdata_q <= grant_d ? d_wdata_i : 32'h0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_en_q <= 1'b0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_zero) begin
                        if (src_q == SRC_D) begin
                            // A write leaves the last read value in place.
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_rdata_i;
                            end
                            d_ready_q <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata_i;
                            if_ready_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requester still holds req this cycle, so no grant here.
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_rdata_o   = if_rdata_q;
    assign if_ready_o   = if_ready_q;
    assign d_rdata_o    = d_rdata_q;
    assign d_ready_o    = d_ready_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign pipe_stall_o = (if_req_i & ~if_ready_q) | (d_req_i & ~d_ready_q);

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Arbitrates one shared single-port unified memory between two requesters: the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sequences each access over a fixed memory latency, returns read data, and raises a pipeline stall while any requester is waiting.
- Sits between the fetch/memory stages and the unified memory; replaces separate instruction and data memories.

Parameters:
- AW, 10, word-address width (word address = byte address [AW+1:2]).
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  AW  fetch word address.
- if_rdata  out  32  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data word address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.
- pipe_stall  out  1  combinational: (if_req & ~if_ready) | (d_req & ~d_ready).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all registered outputs 0; last_grant=fetch.
  - Any in-flight access is abandoned; its mem_rdata is never captured.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req is high, latch the winner's address, we and wdata into the mem_* registers, record the granted source, and go to ISSUE.
  - If both reqs are high, data wins (fixed priority).
- ISSUE (1 cycle):
  - mem_en=1, with mem_we, mem_addr and mem_wdata driven from the latched values.
  - Load the latency counter with MEM_LAT-1; go to WAIT.
- WAIT (exactly MEM_LAT cycles):
  - mem_en=0; counter decrements.
  - At counter==0, capture mem_rdata into the granted side's rdata register and go to DONE.
- DONE (1 cycle):
  - Granted side's ready=1; its rdata holds the captured value.
  - No new grant is made in DONE, because the requester still holds req during this cycle.
  - Return to IDLE.
- Latency: req seen in IDLE at cycle T -> ready at T+MEM_LAT+2.
  - MEM_LAT=2 gives ready at T+4; minimum service interval is MEM_LAT+3 cycles.
- Writes use identical timing. The data-side rdata register is not updated on a write and holds its previous value.
- rdata registers hold their value after ready drops until the next completion for that side.
- Requester inputs are sampled only in IDLE; changes during ISSUE/WAIT/DONE are ignored.
- A req dropped mid-transaction (protocol violation) does not abort: the access completes and ready still pulses.
- Non-granted side: ready=0 throughout; its req stays pending and is evaluated at the next IDLE.
- if_ready and d_ready are never high in the same cycle. mem_en is never high on two consecutive cycles.

Optional Feature:
- Macro: PIPE_MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests the side opposite last_grant wins; last_grant updates on every grant. A single requester always wins.
- Undefined: fixed data-over-fetch priority; last_grant logic is not generated.

Decomposition:
- Shared package pipe_mem_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - grant-source encoding (SRC_IF=0, SRC_D=1);
  - default AW and MEM_LAT constants.
- One natural sub-module: pipe_mem_lat_cnt, the loadable down-counter (width 4) with load, decrement and a zero flag. The FSM and the output registers stay in the top module.

Test Plan:
- Reset: assert reset mid-WAIT after a fetch issues to 0x010 -> all outputs 0 immediately; after release, no if_ready pulse for the abandoned access; if_req still high -> fresh issue.
- Single fetch: if_req=1, if_addr=0x004, memory returns 0x8C220000 -> mem_en at T+1 with mem_addr=0x004; if_ready=1 and if_rdata=0x8C220000 at T+4 (MEM_LAT=2); pipe_stall=1 from T to T+3.
- Data write: d_req=1, d_we=1, d_addr=0x020, d_wdata=0xDEADBEEF -> one mem_en cycle with mem_we=1 carrying exactly these values; d_ready at T+4; d_rdata unchanged.
- Contention: if_req and d_req rise together -> data granted first (d_ready at T+4); fetch mem_en at T+6, if_ready at T+9. With PIPE_MEM_ARB_RR_EN and last_grant=data, fetch is served first instead.
- Back-to-back fetches: two fetches to 0x000 then 0x001 -> mem_en pulses exactly 5 cycles apart; the two if_ready pulses are never adjacent.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15 -> ready at T+3 and T+17 respectively, with correct data captured.
